// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: loads two operands, feeds an external
// single-bit full-adder cell LSB-first, holds the carry between bit-times
// and reassembles the serial sum into a parallel result.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   // The cell only sees live operand bits during bit-times; idle at zero otherwise.
   always_comb begin
      busy   = (state == SHIFT);
      fa_a   = busy & a_sr[0];
      fa_b   = busy & b_sr[0];
      fa_cin = busy & carry;
   end

   // Sequencer: accept in IDLE, one bit per clock in SHIFT, one-cycle DONE pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
               carry  <= fa_cout;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  // MSB bit-time: carry into MSB is fa_cin, so overflow is the
                  // disagreement between carry-in and carry-out of that bit.
                  sum   <= {fa_s, sum_sr[WIDTH-1:1]};
                  cout  <= fa_cout;
                  ovf   <= fa_cin ^ fa_cout;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl with a behavioural full-adder cell.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;
   logic             busy, done, cout, ovf;
   logic [WIDTH-1:0] sum;

   int total = 0;
   int bad = 0;
   logic [9:0] exp_q[$];   // {ovf, cout, sum}
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   // behavioural full-adder cell
   assign fa_s    = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // monitor: pops expected result on every done pulse; checks idle gating
   always @(negedge clk) begin
      if (rst) begin
         prev_done = 1'b0;
      end else begin
         if (!busy) check("fa_idle_zero", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
         if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
               check("result", {22'd0, ovf, cout, sum}, {22'd0, exp_q.pop_front()});
            end
         end
         prev_done = done;
      end
   end

   task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input logic [7:0] es, input logic ec, input logic eo);
      int n, bc;
      @(negedge clk);
      a = av; b = bv; cin = ci; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_q.push_back({eo, ec, es});
      check("busy_at_e0", {31'd0, busy}, 32'd1);
      n = 0; bc = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (busy) bc++;
      end
      check("latency", n - 1, 8);
      check("busy_cycles", bc, 8);
      @(negedge clk);
      check("done_low_after", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int n, k;
      int idx[8];

      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_res", {22'd0, ovf, cout, sum}, 0);
      rst = 1'b0;

      // basic, carry ripple, signed overflow
      run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // start while busy: second request held high until accepted at E_WIDTH+2
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      exp_q.push_back({2'b00, 8'h30});
      exp_q.push_back({2'b00, 8'h02});
      repeat (3) @(negedge clk);
      a = 8'h01; b = 8'h01; start = 1'b1;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      check("busy_run1_done_seen", {31'd0, done}, 1);
      @(negedge clk);
      check("gap_idle", {31'd0, busy}, 0);
      @(negedge clk);
      check("accept_e_width_plus_2", {31'd0, busy}, 1);
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         check("sum_held", {24'd0, sum}, 32'h30);
         @(negedge clk);
         n++;
      end
      check("run2_done_seen", {31'd0, done}, 1);
      @(negedge clk);

      // reset mid-operation (sum currently 0x02, so clearing is visible)
      @(negedge clk);
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_done", {31'd0, done}, 0);
      check("abort_res", {22'd0, ovf, cout, sum}, 0);
      check("abort_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) k++;
      end
      check("no_done_after_abort", k, 0);
      run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

      // continuous start: a result every WIDTH+2 cycles
      for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, 8'h08});
      @(negedge clk);
      a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
      k = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            if (k < 8) idx[k] = i;
            k++;
         end
      end
      start = 1'b0;
      check("pulse_count", k, 4);
      if (k >= 1) check("first_pulse", idx[0], 8);
      for (int i = 1; i < 4; i++)
         if (i < k) check("pulse_spacing", idx[i] - idx[i-1], 10);

      repeat (12) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard stop in case anything stalls
   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish before 100000");
      $fatal(1);
   end

endmodule
